overture_run_ctrl: RTL and testbench

- Run/debug sequencer for the overture CPU program wrappers (pgm_overture_*).
- Owns the CPU `run` enable and drives it from host commands: free-run, halt, N-instruction single-step, and one PC breakpoint.
- A watchdog halts a runaway program.
- Reports a cycle count, the halt cause, and a strobe whenever the CPU output port changes.
- Sits between the bench/host and the CPU wrapper; the CPU itself is untouched.

---
 rtl/overture_pkg.sv | 25 ++
 rtl/overture_out_monitor.sv | 41 ++++
 rtl/overture_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_overture_run_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/overture_pkg.sv
// Shared types for the overture run/debug controller: host opcodes, halt causes
// and controller states.
package overture_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALT   = 2'd1,
    STEP   = 2'd2,
    SET_BP = 2'd3
  } ctrl_op_e;

  typedef enum logic [1:0] {
    HOST       = 2'd0,
    STEP_DONE  = 2'd1,
    BREAKPOINT = 2'd2,
    WATCHDOG   = 2'd3
  } halt_cause_e;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/overture_out_monitor.sv
// Watches the CPU output port and emits a one-cycle strobe plus the new value
// whenever it changes as a result of an executed instruction.
module overture_out_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] cpu_out,
  output logic       out_strobe,
  output logic [7:0] out_data
);

  logic       run_q;
  logic [7:0] prev_out_q;
  logic       strobe_q, strobe_d;
  logic [7:0] data_q, data_d;

  // run_q lets the write of the final executed instruction still be seen
  // after run has already dropped.
  always_comb begin
    strobe_d = run_q && (cpu_out != prev_out_q);
    data_d   = strobe_d ? cpu_out : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= 1'b0;
      prev_out_q <= 8'd0;
      strobe_q   <= 1'b0;
      data_q     <= 8'd0;
    end else begin
      run_q      <= run;
      prev_out_q <= cpu_out;
      strobe_q   <= strobe_d;
      data_q     <= data_d;
    end
  end

  assign out_strobe = strobe_q;
  assign out_data   = data_q;

endmodule

// File: rtl/overture_run_ctrl.sv
// Run/debug sequencer for the overture CPU wrappers: owns the CPU run enable and
// implements free-run, halt, N-step, one PC breakpoint and a watchdog.
module overture_run_ctrl
  import overture_pkg::*;
#(
  parameter logic [15:0] WD_LIMIT = 16'd4096,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [8:0]       cmd_data,
  input  logic [7:0]       cpu_pc,
  input  logic [7:0]       cpu_out,
  output logic             run,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic             out_strobe,
  output logic [7:0]       out_data
);

  localparam bit WD_EN = (WD_LIMIT != 16'd0);

  ctrl_state_e      state_q, state_d;
  halt_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             bp_en_q, bp_en_d;
  logic [7:0]       bp_addr_q, bp_addr_d;
  logic [7:0]       step_q, step_d;
  logic [15:0]      wd_q, wd_d;
  logic             skip_q, skip_d;
  logic             bp_block;

  // Host commands have no ready: cmd_valid is a one-cycle strobe and every
  // command is consumed (or ignored) in the cycle it is presented.
  ctrl_op_e op;
  logic     cmd_run, cmd_halt, cmd_step, cmd_setbp;
  assign op        = ctrl_op_e'(cmd_op);
  assign cmd_run   = cmd_valid && (op == RUN);
  assign cmd_halt  = cmd_valid && (op == HALT);
  assign cmd_step  = cmd_valid && (op == STEP);
  assign cmd_setbp = cmd_valid && (op == SET_BP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HALTED;
      cause_q   <= HOST;
      cycle_q   <= '0;
      bp_en_q   <= 1'b0;
      bp_addr_q <= 8'd0;
      step_q    <= 8'd0;
      wd_q      <= 16'd0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      step_q    <= step_d;
      wd_q      <= wd_d;
      skip_q    <= skip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    cycle_d   = cycle_q;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    step_d    = step_q;
    wd_d      = wd_q;
    skip_d    = skip_q;

    if (run) begin
      cycle_d = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
      wd_d    = wd_q + 16'd1;
      skip_d  = 1'b0;
      if (state_q == STEPPING) step_d = step_q - 8'd1;
    end

    if (cmd_setbp) begin
      bp_en_d   = cmd_data[8];
      bp_addr_d = cmd_data[7:0];
    end

    // Priority: HALT command > breakpoint > watchdog > step done.
    if (cmd_halt) begin
      state_d = HALTED;
      cause_d = HOST;
    end else begin
      unique case (state_q)
        HALTED: begin
          if (cmd_run) begin
            state_d = RUNNING;
            wd_d    = 16'd0;
            skip_d  = 1'b1;
          end else if (cmd_step) begin
            state_d = STEPPING;
            step_d  = (cmd_data[7:0] == 8'd0) ? 8'd1 : cmd_data[7:0];
            wd_d    = 16'd0;
            skip_d  = 1'b1;
          end
        end
        RUNNING, STEPPING: begin
          if (bp_block) begin
            state_d = HALTED;
            cause_d = BREAKPOINT;
          end else if (WD_EN && (wd_q == WD_LIMIT - 16'd1)) begin
            state_d = HALTED;
            cause_d = WATCHDOG;
          end else if ((state_q == STEPPING) && (step_q == 8'd1)) begin
            state_d = HALTED;
            cause_d = STEP_DONE;
          end
        end
        default: state_d = HALTED;
      endcase
    end
  end

  // skip_bp lets a resume from the breakpoint PC execute that instruction once.
  always_comb begin
    bp_block = bp_en_q && (cpu_pc == bp_addr_q) && !skip_q;
    run      = (state_q != HALTED) && !bp_block;
    halted   = (state_q == HALTED);
  end

  assign halt_cause  = cause_q;
  assign cycle_count = cycle_q;

  overture_out_monitor u_out_monitor (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .cpu_out    (cpu_out),
    .out_strobe (out_strobe),
    .out_data   (out_data)
  );

endmodule

// File: tb/tb_overture_run_ctrl.sv
// Bench for overture_run_ctrl: a toy CPU (pc+1 per run cycle, table-driven output
// writes) plus a transaction-level model predicting each command's outcome.
module tb_overture_run_ctrl;

  localparam int WD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [8:0]  cmd_data = 9'd0;
  logic [7:0]  cpu_pc;
  logic [7:0]  cpu_out;
  logic        run;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [15:0] cycle_count;
  logic        out_strobe;
  logic [7:0]  out_data;

  always #5 clk = ~clk;

  overture_run_ctrl #(.WD_LIMIT(16'd16), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .cpu_pc      (cpu_pc),
    .cpu_out     (cpu_out),
    .run         (run),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count),
    .out_strobe  (out_strobe),
    .out_data    (out_data)
  );

  // Toy CPU: one instruction per run cycle, optional output write per address.
  bit         prog_wr [256];
  logic [7:0] prog_val[256];

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_pc  <= 8'd0;
      cpu_out <= 8'd0;
    end else if (run) begin
      cpu_pc <= cpu_pc + 8'd1;
      if (prog_wr[cpu_pc]) cpu_out <= prog_val[cpu_pc];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int         m_pc, m_cycles, m_bp;
  bit         m_bp_en;
  logic [7:0] m_out, m_out_data;

  task automatic model_reset();
    m_pc = 0; m_cycles = 0; m_bp = 0; m_bp_en = 0; m_out = 8'd0; m_out_data = 8'd0;
  endtask

  task automatic send_cmd(input int op, input int data);
    cmd_op = op[1:0]; cmd_data = data[8:0]; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts run cycles until halted; optional command injected at cycle inj_at.
  task automatic measure(input int inj_at, input int inj_op, input int inj_data,
                         output int cyc, output int strb, output bit to);
    int k;
    cyc = 0; strb = 0; to = 0; k = 0;
    forever begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (out_strobe) strb++;
      if (halted) break;
      if (run) cyc++;
      if (k == inj_at) begin
        cmd_op = inj_op[1:0]; cmd_data = inj_data[8:0]; cmd_valid = 1'b1;
      end
      k++;
      if (k > 200) begin to = 1; break; end
    end
    repeat (3) begin
      @(negedge clk);
      if (out_strobe) strb++;
    end
  endtask

  task automatic run_txn(input string tag, input int op, input int n,
                         input int inj_at, input int inj_op, input int inj_data);
    int neff, lim, d, exp_cyc, exp_cause, exp_strb, p, cyc, strb;
    bit to;
    neff = (op == 2) ? ((n == 0) ? 1 : n) : 100000;
    lim  = (neff < WD) ? neff : WD;
    d    = (m_bp_en && (m_bp != m_pc)) ? ((m_bp - m_pc) & 255) : 100000;
    exp_cyc   = (d < lim) ? d : lim;
    exp_cause = (d < lim) ? 2 : ((neff < WD) ? 1 : 3);
    exp_strb  = 0;
    for (int i = 0; i < exp_cyc; i++) begin
      p = (m_pc + i) & 255;
      if (prog_wr[p] && (prog_val[p] != m_out)) begin
        exp_strb++; m_out = prog_val[p]; m_out_data = prog_val[p];
      end
    end
    m_pc     = (m_pc + exp_cyc) & 255;
    m_cycles = m_cycles + exp_cyc;

    send_cmd(op, n);
    measure(inj_at, inj_op, inj_data, cyc, strb, to);
    check({tag, "_timeout"}, 32'(to), 32'd0);
    check({tag, "_run_cycles"}, cyc, exp_cyc);
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_cause"}, 32'(halt_cause), exp_cause);
    check({tag, "_cycle_count"}, 32'(cycle_count), m_cycles & 16'hFFFF);
    check({tag, "_pc"}, 32'(cpu_pc), m_pc);
    check({tag, "_strobes"}, strb, exp_strb);
    check({tag, "_out_data"}, 32'(out_data), 32'(m_out_data));
  endtask

  initial begin
    int cyc, strb, r, idx, n, addr;
    bit to;

    for (int i = 0; i < 256; i++) begin prog_wr[i] = 0; prog_val[i] = 8'd0; end
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_run", 32'(run), 0);
    check("rst_halted", 32'(halted), 1);
    check("rst_cause", 32'(halt_cause), 0);
    check("rst_cycle_count", 32'(cycle_count), 0);
    check("rst_strobe", 32'(out_strobe), 0);
    check("rst_out_data", 32'(out_data), 0);

    // STEP 3 from pc 0
    run_txn("step3", 2, 3, -1, 0, 0);
    check("step3_cause_const", 32'(halt_cause), 1);
    check("step3_count_const", 32'(cycle_count), 3);

    // Breakpoint at 5, then resume through it
    send_cmd(3, 9'h105); @(negedge clk);
    m_bp_en = 1; m_bp = 5;
    run_txn("bp5", 0, 0, -1, 0, 0);
    check("bp5_pc_const", 32'(cpu_pc), 5);
    check("bp5_cause_const", 32'(halt_cause), 2);
    run_txn("bp5_resume", 0, 0, -1, 0, 0);
    check("wd_cause_const", 32'(halt_cause), 3);

    // HALT arrives in the same cycle the breakpoint PC is reached: HOST wins
    addr = (m_pc + 10) & 255;
    send_cmd(3, 256 + addr); @(negedge clk);
    m_bp_en = 1; m_bp = addr;
    send_cmd(0, 0);
    measure(10, 1, 0, cyc, strb, to);
    m_pc = addr; m_cycles = m_cycles + 10;
    check("halt_vs_bp_timeout", 32'(to), 0);
    check("halt_vs_bp_cycles", cyc, 10);
    check("halt_vs_bp_cause", 32'(halt_cause), 0);
    check("halt_vs_bp_pc", 32'(cpu_pc), addr);
    run_txn("step0", 2, 0, -1, 0, 0);

    // Output write of 8'h2A, then rewriting the same value
    prog_wr[m_pc] = 1; prog_val[m_pc] = 8'h2A;
    run_txn("out_2a", 2, 1, -1, 0, 0);
    check("out_2a_data_const", 32'(out_data), 32'h2A);
    prog_wr[m_pc] = 1; prog_val[m_pc] = 8'h2A;
    run_txn("out_2a_again", 2, 1, -1, 0, 0);

    // Randomized command sequence
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        addr = (m_pc + $urandom_range(0, 20)) & 255;
        n = $urandom_range(0, 1);
        send_cmd(3, n * 256 + addr); @(negedge clk);
        m_bp_en = n[0]; m_bp = addr;
      end
      for (int j = 0; j < 20; j++) begin
        idx = (m_pc + j) & 255;
        prog_wr[idx]  = ($urandom_range(0, 2) == 0);
        prog_val[idx] = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 0) run_txn("rnd_run", 0, 0, -1, 0, 0);
      else run_txn("rnd_step", 2, $urandom_range(0, 20), -1, 0, 0);
    end

    // Reset while RUNNING with a breakpoint armed
    for (int i = 0; i < 256; i++) prog_wr[i] = 0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    model_reset();
    send_cmd(3, 9'h106); @(negedge clk);
    send_cmd(0, 0);
    repeat (3) @(negedge clk);
    check("pre_reset_run", 32'(run), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_run", 32'(run), 0);
    check("mid_reset_halted", 32'(halted), 1);
    check("mid_reset_count", 32'(cycle_count), 0);
    check("mid_reset_pc", 32'(cpu_pc), 0);
    reset = 1'b0;
    model_reset();
    // Breakpoint at 6 must be gone; a RUN while running is ignored
    run_txn("post_reset_run", 0, 0, 4, 0, 0);
    check("post_reset_cause_const", 32'(halt_cause), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
